// File: rtl/alu_result_writeback.sv
// ALU result write-back: latches low/high results and writes them to memory over the shared bus.
// Latency: start -> next_state after 2 (low only) or 3 (low+high) active edges with immediate grant/ack.
// Backpressure: waits on bus_grant/bus_ack; optional give-up after TIMEOUT_CYC cycles (ALU_WB_TIMEOUT_EN).
module alu_result_writeback #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_oe,
  input  logic              start,
  input  logic [DATA_W-1:0] dst_in,
  input  logic [DATA_W-1:0] dst_h_in,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] dst_h_addr,
  input  logic              wr_h,
  input  logic              bus_grant,
  input  logic              bus_ack,
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              next_state,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] lo_dat;
  logic [DATA_W-1:0] hi_dat;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic              wr_h_q;
  logic              timeout;

`ifdef ALU_WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive waiting edge in the current state.
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clk_oe) begin
      unique case (state)
        S_REQ:   wait_cnt <= bus_grant ? '0 : wait_cnt + CNT_W'(1);
        S_WR_LO: wait_cnt <= bus_ack   ? '0 : wait_cnt + CNT_W'(1);
        S_WR_HI: wait_cnt <= bus_ack   ? '0 : wait_cnt + CNT_W'(1);
        default: wait_cnt <= '0;
      endcase
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lo_dat     <= '0;
      hi_dat     <= '0;
      lo_addr    <= '0;
      hi_addr    <= '0;
      wr_h_q     <= 1'b0;
      bus_req    <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
      next_state <= 1'b0;
      err        <= 1'b0;
    end else if (clk_oe) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            lo_dat  <= dst_in;
            hi_dat  <= dst_h_in;
            lo_addr <= dst_addr;
            hi_addr <= dst_h_addr;
            wr_h_q  <= wr_h;
            err     <= 1'b0;
            bus_req <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (bus_grant) begin
            bus_write <= 1'b1;
            bus_addr  <= lo_addr;
            bus_data  <= lo_dat;
            state     <= S_WR_LO;
          end else if (timeout) begin
            bus_req    <= 1'b0;
            err        <= 1'b1;
            next_state <= 1'b1;
            state      <= S_DONE;
          end
        end

        // Grant is held from REQ through the final ack; only ack advances.
        S_WR_LO: begin
          if (bus_ack && wr_h_q) begin
            bus_addr <= hi_addr;
            bus_data <= hi_dat;
            state    <= S_WR_HI;
          end else if (bus_ack) begin
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            next_state <= 1'b1;
            state      <= S_DONE;
          end else if (timeout) begin
            bus_req    <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            err        <= 1'b1;
            next_state <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_WR_HI: begin
          if (bus_ack || timeout) begin
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            next_state <= 1'b1;
            state      <= S_DONE;
            if (!bus_ack) begin
              bus_req <= 1'b0;
              err     <= 1'b1;
            end
          end
        end

        S_DONE: begin
          next_state <= 1'b0;
          bus_req    <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          bus_req    <= 1'b0;
          bus_write  <= 1'b0;
          bus_addr   <= '0;
          bus_data   <= '0;
          next_state <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback; timeout scenario follows ALU_WB_TIMEOUT_EN.
module tb_alu_result_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_oe = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_in = '0;
  logic [31:0] dst_h_in = '0;
  logic [31:0] dst_addr = '0;
  logic [31:0] dst_h_addr = '0;
  logic        wr_h = 1'b0;
  logic        bus_grant = 1'b0;
  logic        bus_ack = 1'b0;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;
  logic        next_state;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;

  alu_result_writeback #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe), .start(start),
    .dst_in(dst_in), .dst_h_in(dst_h_in), .dst_addr(dst_addr), .dst_h_addr(dst_h_addr),
    .wr_h(wr_h), .bus_grant(bus_grant), .bus_ack(bus_ack),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_data(bus_data),
    .next_state(next_state), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_oe = 1'b0; start = 1'b1;
    tick(); tick();
    n_chk++; if ({bus_req, bus_write, next_state, err} !== 4'b0000) $display("FAIL reset_ctrl got %b want 0000", {bus_req, bus_write, next_state, err}); else n_pass++;
    n_chk++; if ({bus_addr, bus_data} !== 64'd0) $display("FAIL reset_bus got %h want 0", {bus_addr, bus_data}); else n_pass++;
    rst = 1'b0; start = 1'b0;
    tick();
    n_chk++; if (bus_req !== 1'b0) $display("FAIL reset_idle_req got %b want 0", bus_req); else n_pass++;
  endtask

  task automatic test_single();
    dst_in = 32'h5; dst_addr = 32'h100; wr_h = 1'b0; bus_grant = 1'b1; bus_ack = 1'b1;
    start = 1'b1; clk_oe = 1'b1;
    tick();  // E
    start = 1'b0;
    n_chk++; if ({bus_req, bus_write} !== 2'b10) $display("FAIL single_E got %b want 10", {bus_req, bus_write}); else n_pass++;
    clk_oe = 1'b0;
    tick();
    n_chk++; if ({bus_req, bus_write, next_state} !== 3'b100) $display("FAIL single_hold got %b want 100", {bus_req, bus_write, next_state}); else n_pass++;
    clk_oe = 1'b1;
    tick();  // E+1
    n_chk++; if ({bus_write, bus_addr, bus_data} !== {1'b1, 32'h100, 32'h5}) $display("FAIL single_wr got %b %h %h want 1 100 5", bus_write, bus_addr, bus_data); else n_pass++;
    n_chk++; if (next_state !== 1'b0) $display("FAIL single_ns_early got %b want 0", next_state); else n_pass++;
    tick();  // E+2
    n_chk++; if ({next_state, bus_write, bus_req} !== 3'b101) $display("FAIL single_E2 got %b want 101", {next_state, bus_write, bus_req}); else n_pass++;
    n_chk++; if ({bus_addr, bus_data} !== 64'd0) $display("FAIL single_bus_zero got %h want 0", {bus_addr, bus_data}); else n_pass++;
    tick();  // E+3
    n_chk++; if ({next_state, bus_req} !== 2'b00) $display("FAIL single_E3 got %b want 00", {next_state, bus_req}); else n_pass++;
  endtask

  task automatic test_mul();
    dst_in = 32'hFFFF_FFFE; dst_h_in = 32'h1; dst_addr = 32'h200; dst_h_addr = 32'h204; wr_h = 1'b1;
    bus_grant = 1'b1; bus_ack = 1'b1; start = 1'b1;
    tick();  // E
    start = 1'b0;
    tick();  // E+1
    n_chk++; if ({bus_req, bus_write, bus_addr, bus_data} !== {2'b11, 32'h200, 32'hFFFF_FFFE}) $display("FAIL mul_lo got %b%b %h %h want 11 200 fffffffe", bus_req, bus_write, bus_addr, bus_data); else n_pass++;
    tick();  // E+2
    n_chk++; if ({bus_req, bus_write, bus_addr, bus_data} !== {2'b11, 32'h204, 32'h1}) $display("FAIL mul_hi got %b%b %h %h want 11 204 1", bus_req, bus_write, bus_addr, bus_data); else n_pass++;
    n_chk++; if (next_state !== 1'b0) $display("FAIL mul_ns_early got %b want 0", next_state); else n_pass++;
    tick();  // E+3
    n_chk++; if ({next_state, bus_write, bus_req} !== 3'b101) $display("FAIL mul_E3 got %b want 101", {next_state, bus_write, bus_req}); else n_pass++;
    tick();  // E+4
    n_chk++; if ({next_state, bus_req} !== 2'b00) $display("FAIL mul_E4 got %b want 00", {next_state, bus_req}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    dst_in = 32'hA1; dst_addr = 32'h400; wr_h = 1'b0; bus_grant = 1'b1; bus_ack = 1'b1; start = 1'b1;
    tick();  // E
    dst_in = 32'hB2; dst_addr = 32'h500;
    tick();  // E+1
    n_chk++; if ({bus_addr, bus_data} !== {32'h400, 32'hA1}) $display("FAIL b2b_first got %h %h want 400 a1", bus_addr, bus_data); else n_pass++;
    tick();  // E+2
    n_chk++; if (next_state !== 1'b1) $display("FAIL b2b_ns got %b want 1", next_state); else n_pass++;
    tick();  // E+3: start on DONE exit ignored
    n_chk++; if (bus_req !== 1'b0) $display("FAIL b2b_ignored got %b want 0", bus_req); else n_pass++;
    tick();  // E+4: accepted
    start = 1'b0;
    n_chk++; if ({bus_req, bus_write} !== 2'b10) $display("FAIL b2b_accept got %b want 10", {bus_req, bus_write}); else n_pass++;
    tick();
    n_chk++; if ({bus_write, bus_addr, bus_data} !== {1'b1, 32'h500, 32'hB2}) $display("FAIL b2b_second got %b %h %h want 1 500 b2", bus_write, bus_addr, bus_data); else n_pass++;
    tick(); tick();
    n_chk++; if ({bus_req, next_state} !== 2'b00) $display("FAIL b2b_end got %b want 00", {bus_req, next_state}); else n_pass++;
  endtask

  task automatic test_delayed();
    dst_in = 32'h1234_5678; dst_addr = 32'h300; wr_h = 1'b0; bus_grant = 1'b0; bus_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    dst_in = 32'hDEAD_BEEF; dst_addr = 32'h999;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if ({bus_req, bus_write} !== 2'b10) $display("FAIL dly_grant_wait%0d got %b want 10", i, {bus_req, bus_write}); else n_pass++;
    end
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({bus_req, bus_write, bus_addr, bus_data} !== {2'b11, 32'h300, 32'h1234_5678}) $display("FAIL dly_ack_wait%0d got %b%b %h %h want 11 300 12345678", i, bus_req, bus_write, bus_addr, bus_data); else n_pass++;
      tick();
    end
    n_chk++; if ({bus_write, next_state} !== 2'b10) $display("FAIL dly_pre_ack got %b want 10", {bus_write, next_state}); else n_pass++;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    n_chk++; if ({bus_write, next_state} !== 2'b01) $display("FAIL dly_ack got %b want 01", {bus_write, next_state}); else n_pass++;
    tick();
    n_chk++; if ({bus_req, next_state} !== 2'b00) $display("FAIL dly_end got %b want 00", {bus_req, next_state}); else n_pass++;
  endtask

  task automatic test_clk_oe();
    dst_in = 32'h77; dst_addr = 32'h600; wr_h = 1'b0; bus_grant = 1'b1; bus_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();  // WR_LO
    bus_ack = 1'b1; clk_oe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if ({bus_write, next_state, bus_data} !== {2'b10, 32'h77}) $display("FAIL oe_hold%0d got %b%b %h want 10 77", i, bus_write, next_state, bus_data); else n_pass++;
    end
    clk_oe = 1'b1;
    tick();
    n_chk++; if ({bus_write, next_state} !== 2'b01) $display("FAIL oe_resume got %b want 01", {bus_write, next_state}); else n_pass++;
    tick();
    n_chk++; if ({bus_req, next_state} !== 2'b00) $display("FAIL oe_end got %b want 00", {bus_req, next_state}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    dst_in = 32'h11; dst_h_in = 32'h22; dst_addr = 32'h700; dst_h_addr = 32'h704; wr_h = 1'b1;
    bus_grant = 1'b1; bus_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus_ack = 1'b1;
    tick();  // WR_HI
    bus_ack = 1'b0;
    n_chk++; if ({bus_write, bus_addr} !== {1'b1, 32'h704}) $display("FAIL rstmid_inhi got %b %h want 1 704", bus_write, bus_addr); else n_pass++;
    rst = 1'b1; clk_oe = 1'b0;
    tick();
    n_chk++; if ({bus_req, bus_write, next_state} !== 3'b000) $display("FAIL rstmid_ctrl got %b want 000", {bus_req, bus_write, next_state}); else n_pass++;
    n_chk++; if ({bus_addr, bus_data} !== 64'd0) $display("FAIL rstmid_bus got %h want 0", {bus_addr, bus_data}); else n_pass++;
    rst = 1'b0; clk_oe = 1'b1;
    dst_in = 32'h33; dst_addr = 32'h800; wr_h = 1'b0; bus_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if (bus_req !== 1'b1) $display("FAIL rstmid_restart got %b want 1", bus_req); else n_pass++;
    tick();
    n_chk++; if ({bus_addr, bus_data} !== {32'h800, 32'h33}) $display("FAIL rstmid_wr got %h %h want 800 33", bus_addr, bus_data); else n_pass++;
    tick();
    n_chk++; if (next_state !== 1'b1) $display("FAIL rstmid_ns got %b want 1", next_state); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    dst_in = 32'h44; dst_addr = 32'h900; wr_h = 1'b0; bus_grant = 1'b0; bus_ack = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
`ifdef ALU_WB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({bus_req, err, next_state} !== 3'b100) $display("FAIL to_wait%0d got %b want 100", i, {bus_req, err, next_state}); else n_pass++;
    end
    tick();
    n_chk++; if ({bus_req, bus_write, err, next_state} !== 4'b0011) $display("FAIL to_fire got %b want 0011", {bus_req, bus_write, err, next_state}); else n_pass++;
    tick();
    n_chk++; if ({err, next_state} !== 2'b10) $display("FAIL to_sticky got %b want 10", {err, next_state}); else n_pass++;
    bus_grant = 1'b1; bus_ack = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++; if ({bus_req, err} !== 2'b10) $display("FAIL to_clear got %b want 10", {bus_req, err}); else n_pass++;
    tick(); tick(); tick();
`else
    for (int i = 0; i < 20; i++) tick();
    n_chk++; if ({bus_req, bus_write, err, next_state} !== 4'b1000) $display("FAIL nto_wait got %b want 1000", {bus_req, bus_write, err, next_state}); else n_pass++;
    bus_grant = 1'b1; bus_ack = 1'b1;
    tick();
    n_chk++; if ({bus_write, bus_addr, bus_data} !== {1'b1, 32'h900, 32'h44}) $display("FAIL nto_wr got %b %h %h want 1 900 44", bus_write, bus_addr, bus_data); else n_pass++;
    tick();
    n_chk++; if ({next_state, err} !== 2'b10) $display("FAIL nto_ns got %b want 10", {next_state, err}); else n_pass++;
    tick();
`endif
    n_chk++; if ({bus_req, next_state} !== 2'b00) $display("FAIL to_end got %b want 00", {bus_req, next_state}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_back_to_back();
    test_delayed();
    test_clk_oe();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
